// File: rtl/ddr_refresh_timer.sv
// Per-rank refresh scheduler: tREFI tick, owed-refresh accounting, tRFC blocking; optional pull-in via DDR_REFRESH_PULLIN_EN.
// Latency: tick registered one cycle after interval wrap, pending/ref_req follow a cycle later; busy for TRFC_CK cycles after accept.
// Backpressure: ref_req holds until ref_ack in an IDLE cycle; owed refreshes saturate at MAX_POSTPONE and flag overflow_err.
module ddr_refresh_timer #(
    parameter int TREFI_CK      = 16667,
    parameter int TRFC_CK       = 1283,
    parameter int MAX_POSTPONE  = 8,
    parameter int URGENT_THRESH = 4,
    parameter int MAX_PULLIN    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       bus_idle,
    input  logic       ref_ack,
    input  logic       clear_err,
    output logic       ref_req,
    output logic       ref_urgent,
    output logic       ref_pullin,
    output logic       ref_busy,
    output logic [3:0] pending,
    output logic       overflow_err
);

    localparam int IW = (TREFI_CK > 2) ? $clog2(TREFI_CK) : 1;
    localparam int RW = (TRFC_CK > 1) ? $clog2(TRFC_CK + 1) : 1;
    localparam logic [IW-1:0] IV_LAST  = IW'(TREFI_CK - 1);
    localparam logic [RW-1:0] RFC_LOAD = RW'(TRFC_CK - 1);
    localparam logic [3:0]    PEND_MAX = 4'(MAX_POSTPONE);
    localparam logic [3:0]    URG_LVL  = 4'(URGENT_THRESH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    logic [IW-1:0] iv_cnt;
    logic          tick;
    logic [RW-1:0] rfc_cnt;
    logic [3:0]    pend;
    logic          ovf;

    logic pullin_req;
    logic credit_dec;
    logic accept;
    logic pend_dec;
    logic pend_inc;

`ifdef DDR_REFRESH_PULLIN_EN
    logic [3:0] credit;
    logic       bus_idle_q;
    logic       credit_inc;

    assign pullin_req = (state == IDLE) && (pend == 4'd0) && bus_idle_q
                        && (credit < 4'(MAX_PULLIN));
    // A tick is absorbed by a refresh already issued ahead of schedule.
    assign credit_dec = tick && (credit != 4'd0);
    assign credit_inc = accept && (pend == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit     <= 4'd0;
            bus_idle_q <= 1'b0;
        end else begin
            bus_idle_q <= bus_idle;
            if (credit_inc && !credit_dec)
                credit <= credit + 4'd1;
            else if (credit_dec && !credit_inc)
                credit <= credit - 4'd1;
        end
    end
`else
    logic unused_pullin_cfg;

    assign pullin_req        = 1'b0;
    assign credit_dec        = 1'b0;
    assign unused_pullin_cfg = bus_idle | (MAX_PULLIN == 0);
`endif

    assign ref_req  = (state == IDLE) && ((pend != 4'd0) || pullin_req);
    assign accept   = ref_req && ref_ack;
    assign pend_dec = accept && (pend != 4'd0);
    assign pend_inc = tick && !credit_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            iv_cnt  <= '0;
            tick    <= 1'b0;
            rfc_cnt <= '0;
            pend    <= 4'd0;
            ovf     <= 1'b0;
        end else begin
            if (!enable) begin
                iv_cnt <= '0;
                tick   <= 1'b0;
            end else if (iv_cnt == IV_LAST) begin
                iv_cnt <= '0;
                tick   <= 1'b1;
            end else begin
                iv_cnt <= iv_cnt + IW'(1);
                tick   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= BUSY;
                        rfc_cnt <= RFC_LOAD;
                    end
                end
                BUSY: begin
                    if (rfc_cnt == '0)
                        state <= IDLE;
                    else
                        rfc_cnt <= rfc_cnt - RW'(1);
                end
                default: state <= IDLE;
            endcase

            // A coincident accept and tick cancel, so only a lone tick can overflow.
            if (pend_inc && !pend_dec) begin
                if (pend < PEND_MAX)
                    pend <= pend + 4'd1;
            end else if (pend_dec && !pend_inc) begin
                pend <= pend - 4'd1;
            end

            if (pend_inc && !pend_dec && (pend >= PEND_MAX))
                ovf <= 1'b1;
            else if (clear_err)
                ovf <= 1'b0;
        end
    end

    assign ref_urgent   = (pend >= URG_LVL);
    assign ref_pullin   = ref_req && (pend == 4'd0);
    assign ref_busy     = (state == BUSY);
    assign pending      = pend;
    assign overflow_err = ovf;

endmodule

// File: tb/tb_ddr_refresh_timer.sv
// Bench for ddr_refresh_timer: directed steps plus random traffic against an event-level reference model.
module tb_ddr_refresh_timer;

    localparam int TREFI = 100;
    localparam int TRFC  = 10;
    localparam int MAXP  = 8;
    localparam int URG   = 4;
    localparam int MAXPI = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       bus_idle = 1'b0;
    logic       ref_ack = 1'b0;
    logic       clear_err = 1'b0;
    logic       ref_req;
    logic       ref_urgent;
    logic       ref_pullin;
    logic       ref_busy;
    logic [3:0] pending;
    logic       overflow_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddr_refresh_timer #(
        .TREFI_CK     (TREFI),
        .TRFC_CK      (TRFC),
        .MAX_POSTPONE (MAXP),
        .URGENT_THRESH(URG),
        .MAX_PULLIN   (MAXPI)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .bus_idle    (bus_idle),
        .ref_ack     (ref_ack),
        .clear_err   (clear_err),
        .ref_req     (ref_req),
        .ref_urgent  (ref_urgent),
        .ref_pullin  (ref_pullin),
        .ref_busy    (ref_busy),
        .pending     (pending),
        .overflow_err(overflow_err)
    );

    // Reference model: edges are numbered from reset release; busy is a window of edge numbers.
    int m_edge;
    int m_run;
    int m_tick_at;
    int m_owed;
    int m_credit;
    int m_busy_until;
    bit m_err;
    bit m_idle_q;

    function automatic bit m_busy();
        return m_edge < m_busy_until;
    endfunction

    function automatic bit m_pull();
`ifdef DDR_REFRESH_PULLIN_EN
        return !m_busy() && (m_owed == 0) && m_idle_q && (m_credit < MAXPI);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_req();
        return !m_busy() && ((m_owed != 0) || m_pull());
    endfunction

    task automatic model_reset();
        m_edge       = 0;
        m_run        = 0;
        m_tick_at    = -1;
        m_owed       = 0;
        m_credit     = 0;
        m_busy_until = 0;
        m_err        = 1'b0;
        m_idle_q     = 1'b0;
    endtask

    task automatic model_edge(input bit en, input bit bi, input bit ack, input bit clr);
        int e;
        int net;
        int cred;
        bit acc;
        e    = m_edge + 1;
        acc  = m_req() && ack;
        net  = m_owed;
        cred = m_credit;
        if (m_tick_at == e) begin
            if (m_credit > 0) cred = cred - 1;
            else              net  = net + 1;
        end
        if (acc) begin
            if (m_owed != 0) net  = net - 1;
            else             cred = cred + 1;
        end
        if (net > MAXP) begin
            net   = MAXP;
            m_err = 1'b1;
        end else if (clr) begin
            m_err = 1'b0;
        end
        m_owed   = net;
        m_credit = cred;
        if (acc) m_busy_until = e + TRFC;
        if (en) begin
            m_run = m_run + 1;
            if (m_run == TREFI) begin
                m_run     = 0;
                m_tick_at = e + 1;
            end
        end else begin
            m_run = 0;
        end
        m_idle_q = bi;
        m_edge   = e;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, expv, m_edge);
        end
    endtask

    task automatic check_model();
        chk("model_ref_req",      32'(ref_req),      32'(m_req()));
        chk("model_ref_urgent",   32'(ref_urgent),   32'(m_owed >= URG));
        chk("model_ref_pullin",   32'(ref_pullin),   32'(m_req() && (m_owed == 0)));
        chk("model_ref_busy",     32'(ref_busy),     32'(m_busy()));
        chk("model_pending",      32'(pending),      32'(m_owed));
        chk("model_overflow_err", 32'(overflow_err), 32'(m_err));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"},     32'(ref_req),      0);
        chk({tag, "_urgent"},  32'(ref_urgent),   0);
        chk({tag, "_pullin"},  32'(ref_pullin),   0);
        chk({tag, "_busy"},    32'(ref_busy),     0);
        chk({tag, "_pending"}, 32'(pending),      0);
        chk({tag, "_err"},     32'(overflow_err), 0);
    endtask

    // Inputs are applied after a falling edge and the DUT is observed at the next falling edge.
    task automatic step(input bit en, input bit bi, input bit ack, input bit clr);
        enable    = en;
        bus_idle  = bi;
        ref_ack   = ack;
        clear_err = clr;
        @(posedge clk);
        model_edge(en, bi, ack, clr);
        @(negedge clk);
        check_model();
    endtask

    task automatic reset_dut(input string tag);
        enable    = 1'b0;
        bus_idle  = 1'b0;
        ref_ack   = 1'b0;
        clear_err = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero(tag);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bit bi;
        int pct;
        int acks;
        bit a;

        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("por");
        rst_n = 1'b1;

        // Basic refresh, then nine unacknowledged intervals into overflow.
        for (int i = 1; i <= 1002; i++) begin
            step(1'b1, 1'b0, i == 110, i == 1002);
            if (i == 100) chk("req_before_first_tick", 32'(ref_req), 0);
            if (i == 101) chk("req_after_first_tick", 32'(ref_req), 1);
            if (i >= 110 && i <= 121) chk("basic_busy_window", 32'(ref_busy), 32'(i <= 119));
            if (i == 121) chk("basic_pending_after_ref", 32'(pending), 0);
            if (i == 121) chk("basic_req_after_ref", 32'(ref_req), 0);
            if (i == 401) chk("urgent_below_thresh", 32'(ref_urgent), 0);
            if (i == 501) chk("urgent_at_thresh", 32'(ref_urgent), 1);
            if (i == 901) chk("pending_at_limit", 32'(pending), 8);
            if (i == 901) chk("no_err_at_limit", 32'(overflow_err), 0);
            if (i == 1001) chk("pending_saturated", 32'(pending), 8);
            if (i == 1001) chk("overflow_set", 32'(overflow_err), 1);
            if (i == 1002) chk("overflow_cleared", 32'(overflow_err), 0);
        end

        // Ack coinciding with a tick, an ack while busy, then reset during tRFC.
        reset_dut("rst_c");
        for (int i = 1; i <= 417; i++) begin
            step(1'b1, 1'b0, (i == 401) || (i == 405) || (i == 413), 1'b0);
            if (i == 301) chk("pend3_before_coincide", 32'(pending), 3);
            if (i == 401) chk("coincide_pending", 32'(pending), 3);
            if (i >= 401 && i <= 412) chk("coincide_busy", 32'(ref_busy), 32'(i <= 410));
            if (i == 405) chk("ack_in_busy_pending", 32'(pending), 3);
            if (i == 414) chk("second_ref_pending", 32'(pending), 2);
        end
        reset_dut("rst_mid_busy");
        for (int i = 1; i <= 101; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 100) chk("post_reset_no_tick", 32'(pending), 0);
            if (i == 101) chk("post_reset_first_tick", 32'(pending), 1);
        end

        // Acks with nothing owed are ignored.
        reset_dut("rst_d");
        for (int i = 1; i <= 50; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("idle_ack_busy", 32'(ref_busy), 0);
        chk("idle_ack_pending", 32'(pending), 0);
        chk("idle_ack_req", 32'(ref_req), 0);

`ifdef DDR_REFRESH_PULLIN_EN
        reset_dut("rst_pullin");
        acks = 0;
        for (int i = 1; i <= 901; i++) begin
            a = m_req() && (acks < 8);
            if (a) acks++;
            step(1'b1, 1'b1, a, 1'b0);
            if (i == 1) chk("pullin_first", 32'(ref_pullin), 1);
            if (i == 100) chk("pullin_credit_full", 32'(ref_req), 0);
            if (i == 900) chk("pullin_ticks_absorbed", 32'(pending), 0);
            if (i == 901) chk("pullin_ninth_tick", 32'(pending), 1);
            if (i == 901) chk("pullin_now_normal", 32'(ref_pullin), 0);
        end
`endif

        // Random traffic with varying ack pressure.
        reset_dut("rst_rand");
        bi = 1'b0;
        for (int blk = 0; blk < 8; blk++) begin
            case (blk % 4)
                0: pct = 0;
                1: pct = 5;
                2: pct = 50;
                default: pct = 95;
            endcase
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(19) == 0) bi = ~bi;
                step($urandom_range(15) != 0, bi, $urandom_range(99) < pct,
                     $urandom_range(49) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
